shift_issue_buffer: RTL and testbench
=====================================

Name: shift_issue_buffer

Overview:
- Two-entry elastic (skid) buffer that sits between decode and the 16-bit barrel shifter in the EX datapath.
- Captures the source operand, the 4-bit immediate shift amount and the opcode under a valid/ready handshake.
- Decodes SLL/SRA into the shifter's Mode bit and presents registered Shift_In / Shift_Val / Mode.
- Absorbs one cycle of downstream back-pressure without losing or duplicating an operation; supports a pipeline flush.

Parameters:
- DATA_W, 16, operand width; must equal the shifter data width.
- OPC_SLL, 4'b0100, opcode decoded as logical left shift (Mode=0).
- OPC_SRA, 4'b0101, opcode decoded as arithmetic right shift (Mode=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream presents an operation.
- in_ready  out  1  buffer can accept; registered, equals (count<2).
- in_opcode  in  4  instruction opcode.
- in_data  in  DATA_W  source register value.
- in_imm  in  4  shift amount.
- flush  in  1  synchronous discard of all buffered entries.
- out_valid  out  1  head entry valid toward shifter.
- out_ready  in  1  downstream consumes head this cycle.
- Shift_In  out  DATA_W  head operand.
- Shift_Val  out  4  head shift amount (0 for non-shift opcodes).
- Mode  out  1  0=SLL, 1=SRA.
- out_opcode  out  4  head opcode, for downstream result selection.

Behaviour:
- State: head and tail entries, each {opcode, data, amt, mode}, plus count in 0..2.
- Reset (async, rst_n=0):
  - count=0, out_valid=0, in_ready=1.
  - Shift_In=0, Shift_Val=0, Mode=0, out_opcode=0.
  - Takes effect immediately, including mid-transfer; buffered entries are lost.
- Decode at push:
  - opcode==OPC_SRA: mode=1, amt=in_imm.
  - opcode==OPC_SLL: mode=0, amt=in_imm.
  - Any other opcode: mode=0, amt=0, so the shifter passes data unchanged. The entry is still buffered and handed over normally.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - out_valid = (count!=0).
  - Outputs always reflect the head entry.
- Transitions, evaluated per edge:
  - flush=1: count<=0 regardless of push/pop; out_valid=0 next cycle. Flush has priority over a same-cycle push, which is discarded.
  - count=0, push: head<=input, count<=1. Latency is one cycle (input at edge N, outputs valid after edge N).
  - count=1, push & !pop: tail<=input, count<=2.
  - count=1, push & pop: head<=input, count stays 1. No bubble.
  - count=1, pop & !push: count<=0.
  - count=2, pop: head<=tail, count<=1. No push is possible since in_ready=0.
  - count=2, !pop: hold.
- Stability rule: while out_valid & !out_ready, Shift_In, Shift_Val, Mode and out_opcode must not change.
- in_ready is a function of registered count only; it has no combinational path from out_ready.
- Order is strictly FIFO; no entry is ever dropped or duplicated except by flush or reset.

Test Plan:
- Reset, then push {OPC_SLL, 16'h0001, 4'd4} with out_ready=1 -> next cycle out_valid=1, Shift_In=16'h0001, Shift_Val=4, Mode=0; the following cycle out_valid=0.
- Push {OPC_SRA, 16'h8000, 4'd3} -> Mode=1, Shift_Val=3; with the shifter attached its output is 16'hF000.
- Hold out_ready=0 and push A=16'h1111 then B=16'h2222:
  - in_ready drops to 0 after the second push.
  - Outputs stay A across 5 stall cycles.
  - Release out_ready -> A then B on consecutive cycles, then in_ready=1.
- Continuous stream of 8 ops with in_valid=out_ready=1 -> one output per cycle, in order, no bubbles after the first.
- Push opcode 4'b0000 with in_imm=4'd7 -> Shift_Val=0, Mode=0, out_opcode=0.
- With count=2, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, pushed op absent. Separately, drop rst_n mid-stall -> out_valid=0 immediately (asynchronously).

Source files
------------

// File: rtl/shift_issue_buffer.sv
// Two-entry skid buffer between decode and the 16-bit barrel shifter.
// Decodes SLL/SRA into the shifter mode bit and presents the head entry as registered outputs.
module shift_issue_buffer #(
  parameter int unsigned DATA_W  = 16,
  parameter logic [3:0]  OPC_SLL = 4'b0100,
  parameter logic [3:0]  OPC_SRA = 4'b0101
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        in_imm,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Shift_In,
  output logic [3:0]        Shift_Val,
  output logic              Mode,
  output logic [3:0]        out_opcode
);

  typedef struct packed {
    logic [3:0]        opcode;
    logic [DATA_W-1:0] data;
    logic [3:0]        amt;
    logic              mode;
  } entry_t;

  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  entry_t     in_entry;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  // Non-shift opcodes get amt=0 so the shifter passes the operand through unchanged.
  always_comb begin
    in_entry        = '0;
    in_entry.opcode = in_opcode;
    in_entry.data   = in_data;
    if (in_opcode == OPC_SRA) begin
      in_entry.mode = 1'b1;
      in_entry.amt  = in_imm;
    end else if (in_opcode == OPC_SLL) begin
      in_entry.mode = 1'b0;
      in_entry.amt  = in_imm;
    end
  end

  // Ready depends only on the registered count, never on out_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case (count_q)
        2'd0: begin
          if (push) begin
            head_d  = in_entry;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_d = in_entry;
          end else if (push) begin
            tail_d  = in_entry;
            count_d = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_d  = tail_q;
            count_d = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign Shift_In   = head_q.data;
  assign Shift_Val  = head_q.amt;
  assign Mode       = head_q.mode;
  assign out_opcode = head_q.opcode;

endmodule

// File: tb/tb_shift_issue_buffer.sv
// Directed self-checking bench for shift_issue_buffer.
module tb_shift_issue_buffer;

  localparam logic [3:0] OpcSll = 4'b0100;
  localparam logic [3:0] OpcSra = 4'b0101;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [15:0] in_data;
  logic [3:0]  in_imm;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] shift_in;
  logic [3:0]  shift_val;
  logic        mode;
  logic [3:0]  out_opcode;

  int n_vec;
  int n_miss;

  shift_issue_buffer #(
    .DATA_W (16),
    .OPC_SLL(OpcSll),
    .OPC_SRA(OpcSra)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_data   (in_data),
    .in_imm    (in_imm),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Shift_In  (shift_in),
    .Shift_Val (shift_val),
    .Mode      (mode),
    .out_opcode(out_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] opc, input logic [15:0] d,
                       input logic [3:0] imm);
    in_valid  = v;
    in_opcode = opc;
    in_data   = d;
    in_imm    = imm;
  endtask

  task automatic check_head(input string tag, input logic [15:0] d, input logic [3:0] amt,
                            input logic m, input logic [3:0] opc);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".data"}, {16'd0, shift_in}, {16'd0, d});
    check({tag, ".amt"}, {28'd0, shift_val}, {28'd0, amt});
    check({tag, ".mode"}, {31'd0, mode}, {31'd0, m});
    check({tag, ".opc"}, {28'd0, out_opcode}, {28'd0, opc});
  endtask

  logic signed [15:0] sra_res;

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 4'd0, 16'd0, 4'd0);
    #1;
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.ready", {31'd0, in_ready}, 32'd1);
    check("rst.data", {16'd0, shift_in}, 32'd0);
    check("rst.amt", {28'd0, shift_val}, 32'd0);
    check("rst.mode", {31'd0, mode}, 32'd0);
    check("rst.opc", {28'd0, out_opcode}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single SLL with one-cycle latency, consumed immediately.
    out_ready = 1'b1;
    drive(1'b1, OpcSll, 16'h0001, 4'd4);
    tick();
    drive(1'b0, 4'd0, 16'd0, 4'd0);
    check_head("sll", 16'h0001, 4'd4, 1'b0, OpcSll);
    tick();
    check("sll.drain", {31'd0, out_valid}, 32'd0);

    // SRA decode plus a shifter model on the presented operand.
    drive(1'b1, OpcSra, 16'h8000, 4'd3);
    tick();
    drive(1'b0, 4'd0, 16'd0, 4'd0);
    check_head("sra", 16'h8000, 4'd3, 1'b1, OpcSra);
    sra_res = $signed(shift_in) >>> shift_val;
    check("sra.shift", {16'd0, sra_res}, 32'h0000_F000);
    tick();
    check("sra.drain", {31'd0, out_valid}, 32'd0);

    // Back-pressure: two entries fill the buffer and hold across a stall.
    out_ready = 1'b0;
    drive(1'b1, OpcSll, 16'h1111, 4'd1);
    tick();
    check("stall.ready1", {31'd0, in_ready}, 32'd1);
    drive(1'b1, OpcSra, 16'h2222, 4'd2);
    tick();
    drive(1'b0, 4'd0, 16'd0, 4'd0);
    check("stall.ready2", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check_head("stall.hold", 16'h1111, 4'd1, 1'b0, OpcSll);
      tick();
    end
    out_ready = 1'b1;
    check_head("stall.a", 16'h1111, 4'd1, 1'b0, OpcSll);
    tick();
    check_head("stall.b", 16'h2222, 4'd2, 1'b1, OpcSra);
    check("stall.ready3", {31'd0, in_ready}, 32'd1);
    tick();
    check("stall.drain", {31'd0, out_valid}, 32'd0);

    // Continuous stream: one output per cycle, no bubbles.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i % 2 == 0) ? OpcSll : OpcSra, 16'h0100 + 16'(i), 4'(i));
      tick();
      check_head("stream", 16'h0100 + 16'(i), 4'(i), (i % 2 == 1), (i % 2 == 0) ? OpcSll : OpcSra);
    end
    drive(1'b0, 4'd0, 16'd0, 4'd0);
    tick();
    check("stream.drain", {31'd0, out_valid}, 32'd0);

    // Non-shift opcode is passed through with a zero shift amount.
    drive(1'b1, 4'b0000, 16'hABCD, 4'd7);
    tick();
    drive(1'b0, 4'd0, 16'd0, 4'd0);
    check_head("nop", 16'hABCD, 4'd0, 1'b0, 4'b0000);
    tick();

    // Flush with a full buffer and a pending in_valid.
    out_ready = 1'b0;
    drive(1'b1, OpcSll, 16'h3333, 4'd1);
    tick();
    drive(1'b1, OpcSll, 16'h4444, 4'd2);
    tick();
    check("fl.full", {31'd0, in_ready}, 32'd0);
    drive(1'b1, OpcSll, 16'h5555, 4'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 4'd0, 16'd0, 4'd0);
    check("fl.valid", {31'd0, out_valid}, 32'd0);
    check("fl.ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("fl.absent", {31'd0, out_valid}, 32'd0);

    // Flush beats a same-cycle push that would otherwise be accepted.
    drive(1'b1, OpcSll, 16'h6666, 4'd1);
    tick();
    drive(1'b1, OpcSra, 16'h7777, 4'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 4'd0, 16'd0, 4'd0);
    check("fl2.valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("fl2.absent", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-stall, away from any clock edge.
    drive(1'b1, OpcSll, 16'h8888, 4'd1);
    tick();
    drive(1'b1, OpcSll, 16'h9999, 4'd2);
    tick();
    drive(1'b0, 4'd0, 16'd0, 4'd0);
    check("ar.pre", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar.valid", {31'd0, out_valid}, 32'd0);
    check("ar.ready", {31'd0, in_ready}, 32'd1);
    check("ar.data", {16'd0, shift_in}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ar.after", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
